uart_rx_frame_ctrl: RTL and testbench

UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_frame_buf.sv | 24 ++
 rtl/uart_rx_frame_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: line rate, default frame marker and the frame
// controller's state encoding.
package uart_pkg;

    localparam int UART_CLK_HZ       = 25_000_000;
    localparam int UART_BAUD         = 115_200;
    localparam int UART_TIMEOUT_BITS = 100;

    // 100 bit times expressed in clocks (217 clocks/bit at 25 MHz).
    localparam int UART_DEF_TIMEOUT  = (UART_CLK_HZ / UART_BAUD) * UART_TIMEOUT_BITS;
    localparam int UART_DEF_MAX_LEN  = 16;

    localparam logic [7:0] UART_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CSUM    = 3'd4,
        ST_DRAIN   = 3'd5
    } frame_state_t;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store: DEPTH x 8 array, synchronous write, asynchronous read.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          i_CLK,
    input  logic          i_WR_EN,
    input  logic [AW-1:0] i_WR_ADDR,
    input  logic [7:0]    i_WR_DATA,
    input  logic [AW-1:0] i_RD_ADDR,
    output logic [7:0]    o_RD_DATA
);

    logic [7:0] r_mem [0:DEPTH-1];

    always_ff @(posedge i_CLK) begin
        if (i_WR_EN) begin
            r_mem[i_WR_ADDR] <= i_WR_DATA;
        end
    end

    assign o_RD_DATA = r_mem[i_RD_ADDR];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame parser for SYNC/ADDR/LEN/payload/CSUM byte streams from a UART
// receiver; buffers the payload and drains it with a valid/ready handshake.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = UART_SYNC_BYTE,
    parameter int         MAX_LEN        = UART_DEF_MAX_LEN,
    parameter int         TIMEOUT_CYCLES = UART_DEF_TIMEOUT
) (
    input  logic       i_CLK,
    input  logic       i_RESET,
    input  logic [7:0] i_RX_DATA,
    input  logic       i_DATA_READY,
    output logic [7:0] o_FRAME_ADDR,
    output logic [7:0] o_FRAME_DATA,
    output logic       o_FRAME_VALID,
    output logic       o_FRAME_LAST,
    input  logic       i_FRAME_READY,
    output logic       o_CSUM_ERR,
    output logic       o_LEN_ERR,
    output logic       o_TIMEOUT,
    output logic       o_OVERRUN
);

    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam int BW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CW-1:0] CNT_EXPIRE = CW'(TIMEOUT_CYCLES - 1);

    frame_state_t  r_state, w_state_next;
    logic [IW-1:0] r_idx, w_idx_next;
    logic [7:0]    r_addr, w_addr_next;
    logic [7:0]    r_len, w_len_next;
    logic [7:0]    r_xor, w_xor_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          r_csum_err, w_csum_err_next;
    logic          r_len_err, w_len_err_next;
    logic          r_timeout, w_timeout_next;
    logic          r_overrun, w_overrun_next;

    logic          w_buf_wr;
    logic [7:0]    w_rd_data;
    logic [7:0]    w_xor_in;
    logic          w_valid;
    logic          w_idx_is_last;
    logic          w_last;
    logic          w_handshake;
    logic          w_counting;
    logic          w_expired;
    logic          w_len_ok;

    assign w_xor_in      = csum_step(r_xor, i_RX_DATA);
    assign w_valid       = (r_state == ST_DRAIN);
    assign w_idx_is_last = (8'(r_idx) == (r_len - 8'd1));
    assign w_last        = w_valid && w_idx_is_last;
    assign w_handshake   = w_valid && i_FRAME_READY;
    assign w_counting    = (r_state == ST_ADDR) || (r_state == ST_LEN) ||
                           (r_state == ST_PAYLOAD) || (r_state == ST_CSUM);
    // A strobe on the expiry cycle wins over the timeout.
    assign w_expired     = (r_cnt == CNT_EXPIRE) && !i_DATA_READY;
    assign w_len_ok      = (i_RX_DATA != 8'd0) && (i_RX_DATA <= 8'(MAX_LEN));

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (BW)
    ) u_buf (
        .i_CLK     (i_CLK),
        .i_WR_EN   (w_buf_wr),
        .i_WR_ADDR (r_idx[BW-1:0]),
        .i_WR_DATA (i_RX_DATA),
        .i_RD_ADDR (r_idx[BW-1:0]),
        .o_RD_DATA (w_rd_data)
    );

    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            r_state    <= ST_HUNT;
            r_idx      <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_xor      <= '0;
            r_cnt      <= '0;
            r_csum_err <= 1'b0;
            r_len_err  <= 1'b0;
            r_timeout  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_idx      <= w_idx_next;
            r_addr     <= w_addr_next;
            r_len      <= w_len_next;
            r_xor      <= w_xor_next;
            r_cnt      <= w_cnt_next;
            r_csum_err <= w_csum_err_next;
            r_len_err  <= w_len_err_next;
            r_timeout  <= w_timeout_next;
            r_overrun  <= w_overrun_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_idx_next      = r_idx;
        w_addr_next     = r_addr;
        w_len_next      = r_len;
        w_xor_next      = r_xor;
        w_cnt_next      = '0;
        w_csum_err_next = 1'b0;
        w_len_err_next  = 1'b0;
        w_timeout_next  = 1'b0;
        w_overrun_next  = 1'b0;
        w_buf_wr        = 1'b0;

        case (r_state)
            ST_HUNT: begin
                if (i_DATA_READY && (i_RX_DATA == SYNC_BYTE)) begin
                    w_state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (i_DATA_READY) begin
                    w_addr_next  = i_RX_DATA;
                    w_xor_next   = i_RX_DATA;
                    w_state_next = ST_LEN;
                end
            end
            ST_LEN: begin
                if (i_DATA_READY) begin
                    if (w_len_ok) begin
                        w_len_next   = i_RX_DATA;
                        w_xor_next   = w_xor_in;
                        w_idx_next   = '0;
                        w_state_next = ST_PAYLOAD;
                    end else begin
                        w_len_err_next = 1'b1;
                        w_state_next   = ST_HUNT;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (i_DATA_READY) begin
                    w_buf_wr   = 1'b1;
                    w_xor_next = w_xor_in;
                    w_idx_next = r_idx + 1'b1;
                    if (w_idx_is_last) begin
                        w_state_next = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (i_DATA_READY) begin
                    if (i_RX_DATA == r_xor) begin
                        w_idx_next   = '0;
                        w_state_next = ST_DRAIN;
                    end else begin
                        w_csum_err_next = 1'b1;
                        w_state_next    = ST_HUNT;
                    end
                end
            end
            ST_DRAIN: begin
                // Bytes arriving while draining are dropped, not buffered.
                w_overrun_next = i_DATA_READY;
                if (w_handshake) begin
                    if (w_idx_is_last) begin
                        w_idx_next   = '0;
                        w_state_next = ST_HUNT;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_HUNT;
            end
        endcase

        if (w_counting) begin
            if (!i_DATA_READY) begin
                w_cnt_next = r_cnt + 1'b1;
            end
            if (w_expired) begin
                w_cnt_next     = '0;
                w_timeout_next = 1'b1;
                w_state_next   = ST_HUNT;
            end
        end
    end

    assign o_FRAME_VALID = w_valid;
    assign o_FRAME_LAST  = w_last;
    assign o_FRAME_DATA  = w_valid ? w_rd_data : 8'd0;
    assign o_FRAME_ADDR  = w_valid ? r_addr : 8'd0;
    assign o_CSUM_ERR    = r_csum_err;
    assign o_LEN_ERR     = r_len_err;
    assign o_TIMEOUT     = r_timeout;
    assign o_OVERRUN     = r_overrun;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: frames are scored by a byte-level
// model, a monitor pops expected beats/pulses as the DUT presents them.
module tb_uart_rx_frame_ctrl;

    localparam int         MAX_LEN = 16;
    localparam int         TO      = 64;
    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int K_LEN  = 1;
    localparam int K_CSUM = 2;
    localparam int K_TO   = 3;
    localparam int K_OVR  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       data_ready;
    logic [7:0] f_addr;
    logic [7:0] f_data;
    logic       f_valid;
    logic       f_last;
    logic       frame_ready;
    logic       csum_err, len_err, timeout, overrun;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl #(
        .SYNC_BYTE      (SYNC),
        .MAX_LEN        (MAX_LEN),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_CLK         (clk),
        .i_RESET       (rst),
        .i_RX_DATA     (rx_data),
        .i_DATA_READY  (data_ready),
        .o_FRAME_ADDR  (f_addr),
        .o_FRAME_DATA  (f_data),
        .o_FRAME_VALID (f_valid),
        .o_FRAME_LAST  (f_last),
        .i_FRAME_READY (frame_ready),
        .o_CSUM_ERR    (csum_err),
        .o_LEN_ERR     (len_err),
        .o_TIMEOUT     (timeout),
        .o_OVERRUN     (overrun)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t      beat_q[$];
    int         err_q[$];
    logic       ready_script[$];
    logic [7:0] fq[$];
    bit         rnd_ready = 1'b0;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return {40'd0, f_valid, f_last, f_data, f_addr, csum_err, len_err, timeout, overrun};
    endfunction

    // Consumer ready: scripted while a drain is in progress, else random or held high.
    initial begin
        frame_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (f_valid && ready_script.size() > 0) frame_ready = ready_script.pop_front();
            else if (rnd_ready) frame_ready = 1'($urandom_range(0, 1));
            else frame_ready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a beat or a pulse.
    initial begin
        logic  pv;
        beat_t prev;
        beat_t e;
        int    n;
        int    k;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
                continue;
            end
            n = int'(csum_err) + int'(len_err) + int'(timeout) + int'(overrun);
            if (n > 1) begin
                check("pulse_exclusive", 64'(n), 64'd1);
            end else if (n == 1) begin
                k = csum_err ? K_CSUM : len_err ? K_LEN : timeout ? K_TO : K_OVR;
                $display("pulse kind=%0d at %0t", k, $time);
                if (err_q.size() == 0) check("pulse_expected", 64'(err_q.size()), 64'd1);
                else check("pulse_kind", 64'(k), 64'(err_q.pop_front()));
            end
            if (pv) begin
                check("stall_valid", 64'(f_valid), 64'd1);
                check("stall_hold", {47'd0, f_addr, f_data, f_last}, {47'd0, prev.addr, prev.data, prev.last});
            end
            if (f_valid && frame_ready) begin
                $display("beat addr=%02h data=%02h last=%0b", f_addr, f_data, f_last);
                if (beat_q.size() == 0) begin
                    check("beat_expected", 64'(beat_q.size()), 64'd1);
                end else begin
                    e = beat_q.pop_front();
                    check("beat_addr", 64'(f_addr), 64'(e.addr));
                    check("beat_data", 64'(f_data), 64'(e.data));
                    check("beat_last", 64'(f_last), 64'(e.last));
                end
            end
            pv = f_valid && !frame_ready;
            prev.addr = f_addr;
            prev.data = f_data;
            prev.last = f_last;
        end
    end

    // Reference model: judge the whole frame in fq from the byte-level rules.
    task automatic model_push();
        int         len;
        logic [7:0] x;
        beat_t      b;
        len = int'(fq[2]);
        if (len == 0 || len > MAX_LEN) begin
            err_q.push_back(K_LEN);
        end else begin
            x = fq[1] ^ fq[2];
            for (int i = 0; i < len; i++) x = x ^ fq[3 + i];
            if (x == fq[3 + len]) begin
                for (int i = 0; i < len; i++) begin
                    b.addr = fq[1];
                    b.data = fq[3 + i];
                    b.last = (i == len - 1);
                    beat_q.push_back(b);
                end
            end else begin
                err_q.push_back(K_CSUM);
            end
        end
    endtask

    task automatic build_frame(input logic [7:0] addr, input int len, input bit good);
        logic [7:0] x;
        logic [7:0] p;
        fq.delete();
        fq.push_back(SYNC);
        fq.push_back(addr);
        fq.push_back(8'(len));
        if (len == 0 || len > MAX_LEN) return;
        x = addr ^ 8'(len);
        for (int i = 0; i < len; i++) begin
            p = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom);
            fq.push_back(p);
            x = x ^ p;
        end
        if (!good) x = x ^ (8'd1 << $urandom_range(0, 7));
        fq.push_back(x);
    endtask

    task automatic strobe(input logic [7:0] b);
        rx_data    = b;
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_fq(input int gap_max);
        $display("frame tx len=%0d bytes=%p", fq.size(), fq);
        for (int i = 0; i < fq.size(); i++) begin
            idle($urandom_range(0, gap_max));
            strobe(fq[i]);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((beat_q.size() != 0 || err_q.size() != 0 || f_valid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("settle_pending", 64'(beat_q.size() + err_q.size() + int'(f_valid)), 64'd0);
        beat_q.delete();
        err_q.delete();
    endtask

    task automatic set_fq6(input logic [7:0] a, b, c, d, e, f);
        fq.delete();
        fq.push_back(a); fq.push_back(b); fq.push_back(c);
        fq.push_back(d); fq.push_back(e); fq.push_back(f);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] nb;
        int         len;
        int         r;
        rst        = 1'b1;
        rx_data    = 8'd0;
        data_ready = 1'b0;
        #1;
        check("reset_outputs", all_outputs(), 64'd0);
        idle(3);
        rst = 1'b0;
        idle(2);

        // Noise in HUNT must not produce anything.
        for (int i = 0; i < 6; i++) begin
            nb = 8'($urandom);
            if (nb == SYNC) nb = 8'h5A;
            strobe(nb);
        end
        wait_idle(20);

        // Golden frame, ready held high.
        set_fq6(8'hA5, 8'h12, 8'h02, 8'h34, 8'h56, 8'h72);
        model_push();
        check("model_golden_beats", 64'(beat_q.size()), 64'd2);
        send_fq(0);
        wait_idle(50);

        // Bad checksum, then a good frame.
        set_fq6(8'hA5, 8'h12, 8'h02, 8'h34, 8'h56, 8'h73);
        model_push();
        send_fq(0);
        wait_idle(50);
        set_fq6(8'hA5, 8'h12, 8'h02, 8'h34, 8'h56, 8'h72);
        model_push();
        send_fq(1);
        wait_idle(50);

        // Length boundaries: 0, MAX_LEN+1, MAX_LEN.
        build_frame(8'h12, 0, 1'b1);
        model_push(); send_fq(0); wait_idle(50);
        build_frame(8'h12, MAX_LEN + 1, 1'b1);
        model_push(); send_fq(0); wait_idle(50);
        build_frame(8'h77, MAX_LEN, 1'b1);
        model_push(); send_fq(0); wait_idle(100);

        // Silence of exactly TO cycles after a payload byte -> timeout.
        fq.delete();
        fq.push_back(8'hA5); fq.push_back(8'h12); fq.push_back(8'h02); fq.push_back(8'h34);
        err_q.push_back(K_TO);
        send_fq(0);
        idle(TO);
        wait_idle(20);

        // Strobe landing exactly on the expiry cycle is processed normally.
        set_fq6(8'hA5, 8'h12, 8'h02, 8'h34, 8'h56, 8'h72);
        model_push();
        strobe(8'hA5); strobe(8'h12); strobe(8'h02); strobe(8'h34);
        idle(TO - 1);
        strobe(8'h56);
        idle(TO - 1);
        strobe(8'h72);
        wait_idle(50);

        // Stalled drain with an injected byte.
        fq.delete();
        fq.push_back(8'hA5); fq.push_back(8'h3C); fq.push_back(8'h03);
        fq.push_back(8'h11); fq.push_back(8'hA5); fq.push_back(8'h22);
        fq.push_back(8'h3C ^ 8'h03 ^ 8'h11 ^ 8'hA5 ^ 8'h22);
        ready_script = '{1'b1, 1'b0, 1'b0, 1'b1};
        model_push();
        send_fq(0);
        check("drain_started", 64'(f_valid), 64'd1);
        err_q.push_back(K_OVR);
        strobe(8'h5A);
        wait_idle(50);

        // Randomised frames and consumer back-pressure.
        rnd_ready = 1'b1;
        for (int f = 0; f < 25; f++) begin
            r = $urandom_range(0, 9);
            if (r == 0) len = 0;
            else if (r == 1) len = MAX_LEN + 1 + $urandom_range(0, 100);
            else len = $urandom_range(1, MAX_LEN);
            build_frame(8'($urandom), len, $urandom_range(0, 3) != 0);
            model_push();
            send_fq(3);
            wait_idle(300);
        end
        rnd_ready = 1'b0;

        // Reset mid-payload.
        fq.delete();
        fq.push_back(8'hA5); fq.push_back(8'h12); fq.push_back(8'h04);
        fq.push_back(8'h11); fq.push_back(8'h22);
        send_fq(0);
        rst = 1'b1;
        #1;
        check("reset_mid_payload", all_outputs(), 64'd0);
        idle(2);
        rst = 1'b0;
        idle(1);
        fq.delete();
        fq.push_back(8'hA5); fq.push_back(8'h01); fq.push_back(8'h01);
        fq.push_back(8'hFF); fq.push_back(8'hFF);
        model_push(); send_fq(0); wait_idle(50);

        // Reset mid-drain while the consumer stalls.
        for (int i = 0; i < 20; i++) ready_script.push_back(1'b0);
        fq.delete();
        fq.push_back(8'hA5); fq.push_back(8'h44); fq.push_back(8'h02);
        fq.push_back(8'hAA); fq.push_back(8'hBB); fq.push_back(8'h44 ^ 8'h02 ^ 8'hAA ^ 8'hBB);
        send_fq(0);
        idle(2);
        check("drain_stalled", 64'(f_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("reset_mid_drain", all_outputs(), 64'd0);
        ready_script.delete();
        idle(2);
        rst = 1'b0;
        idle(1);
        fq.delete();
        fq.push_back(8'hA5); fq.push_back(8'h01); fq.push_back(8'h01);
        fq.push_back(8'hFF); fq.push_back(8'hFF);
        model_push(); send_fq(0); wait_idle(50);

        idle(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
